// File: rtl/dispatch_queue_pkg.sv
// Shared constants, instruction-type encoding and packet/decode field offsets for the dispatcher.
`default_nettype none

package dispatch_queue_pkg;

    localparam int WORD         = 32;
    localparam int PKT_W        = 97;
    localparam int ZERO_ROB_IDX = 0;
    localparam int OPT_LUI      = 1;
    localparam logic [WORD-1:0] NEXT_PC_INC = 32'd4;

    // if_pkt = {pb_tk, mis_pc, cur_pc, inst}
    localparam int PKT_INST_LSB   = 0;
    localparam int PKT_CUR_PC_LSB = 32;
    localparam int PKT_MIS_PC_LSB = 64;
    localparam int PKT_META_LSB   = 32;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } inst_type_e;

    // dec_info = {is_ls, imm, rs2, rs1, rd, opt, ty}
    localparam int DEC_TY_LSB  = 0;
    localparam int DEC_OPT_LSB = 3;
    function automatic int dec_rd_lsb(input int opt_w);    return 3 + opt_w;  endfunction
    function automatic int dec_rs1_lsb(input int opt_w);   return 8 + opt_w;  endfunction
    function automatic int dec_rs2_lsb(input int opt_w);   return 13 + opt_w; endfunction
    function automatic int dec_imm_lsb(input int opt_w);   return 18 + opt_w; endfunction
    function automatic int dec_is_ls_bit(input int opt_w); return 50 + opt_w; endfunction
    function automatic int dec_info_w(input int opt_w);    return 51 + opt_w; endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_fifo.sv
// Circular in-order fetch buffer with push, pop, flush, full/empty flags and a head view.
`default_nettype none

module dispatch_fifo
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PKT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_push, w_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i & ~full_o & ~flush_i;
    assign w_pop   = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/dispatch_queue.sv
// Dispatcher: buffers fetched packets, resolves head operands and issues one registered op per cycle.
// Optional CDB forwarding enabled by defining DISPATCH_CDB_BYPASS_EN.
`default_nettype none

module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = 4,
    parameter int OPT_W   = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy_i,
    input  logic                        flush_i,
    input  logic                        if_valid_i,
    output logic                        if_ready_o,
    input  logic [PKT_W-1:0]            if_pkt_i,
    output logic [WORD-1:0]             dec_inst_o,
    input  logic [dec_info_w(OPT_W)-1:0] dec_info_i,
    output logic [9:0]                  reg_rs_o,
    input  logic [2*ROB_W-1:0]          reg_src_i,
    input  logic [2*WORD-1:0]           reg_val_i,
    input  logic                        rob_full_i,
    input  logic [ROB_W-1:0]            rob_idx_i,
    output logic [2*ROB_W-1:0]          rob_src_o,
    input  logic [1:0]                  rob_rdy_i,
    input  logic [2*WORD-1:0]           rob_val_i,
    input  logic                        rs_full_i,
    input  logic                        slb_full_i,
    input  logic [NUM_CDB-1:0]          cdb_valid_i,
    input  logic [NUM_CDB*ROB_W-1:0]    cdb_src_i,
    input  logic [NUM_CDB*WORD-1:0]     cdb_val_i,
    output logic                        rs_ena_o,
    output logic                        slb_ena_o,
    output logic                        rob_ena_o,
    output logic [OPT_W-1:0]            iss_opt_o,
    output logic [2*ROB_W-1:0]          iss_src_o,
    output logic [2*WORD-1:0]           iss_val_o,
    output logic [WORD-1:0]             iss_imm_o,
    output logic [ROB_W-1:0]            iss_rob_idx_o,
    output logic                        iss_isld_o,
    output logic [4:0]                  rob_dest_o,
    output logic [64:0]                 rob_meta_o,
    output logic                        rn_ena_o
);

    logic             w_push, w_pop, w_full, w_empty, w_flush, w_stall;
    logic [PKT_W-1:0] w_head;

    assign w_flush = rdy_i & flush_i;
    assign w_push  = rdy_i & ~flush_i & if_valid_i & ~w_full;

    dispatch_fifo #(.DEPTH(DEPTH), .WIDTH(PKT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .data_i  (if_pkt_i),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    logic [2:0]       w_ty;
    logic [OPT_W-1:0] w_opt;
    logic [4:0]       w_rd, w_rs1, w_rs2;
    logic [WORD-1:0]  w_imm, w_cur_pc;
    logic             w_is_ls;

    assign w_ty      = dec_info_i[DEC_TY_LSB +: 3];
    assign w_opt     = dec_info_i[DEC_OPT_LSB +: OPT_W];
    assign w_rd      = dec_info_i[dec_rd_lsb(OPT_W) +: 5];
    assign w_rs1     = dec_info_i[dec_rs1_lsb(OPT_W) +: 5];
    assign w_rs2     = dec_info_i[dec_rs2_lsb(OPT_W) +: 5];
    assign w_imm     = dec_info_i[dec_imm_lsb(OPT_W) +: WORD];
    assign w_is_ls   = dec_info_i[dec_is_ls_bit(OPT_W)];
    assign w_cur_pc  = w_head[PKT_CUR_PC_LSB +: WORD];

    assign if_ready_o = ~w_full;
    assign dec_inst_o = w_head[PKT_INST_LSB +: WORD];
    assign reg_rs_o   = {w_rs2, w_rs1};
    assign rob_src_o  = reg_src_i;
    assign w_stall    = rob_full_i | (w_is_ls ? slb_full_i : rs_full_i);
    assign w_pop      = rdy_i & ~flush_i & ~w_empty & ~w_stall;

`ifndef DISPATCH_CDB_BYPASS_EN
    logic w_unused_cdb;
    assign w_unused_cdb = ^{cdb_valid_i, cdb_src_i, cdb_val_i};
`endif

    // Returns {tag, value}; a zero tag means the value is final.
    function automatic logic [ROB_W+WORD-1:0] resolve(input logic [ROB_W-1:0] src,
                                                      input logic            rob_ready,
                                                      input logic [WORD-1:0] reg_v,
                                                      input logic [WORD-1:0] rob_v);
        logic [ROB_W+WORD-1:0] r;
        if (src == ROB_W'(ZERO_ROB_IDX))  r = {{ROB_W{1'b0}}, reg_v};
        else if (rob_ready)               r = {{ROB_W{1'b0}}, rob_v};
        else begin
            r = {src, {WORD{1'b0}}};
`ifdef DISPATCH_CDB_BYPASS_EN
            // Descending scan so the lowest-numbered matching channel is applied last.
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid_i[k] && (cdb_src_i[k*ROB_W +: ROB_W] == src))
                    r = {{ROB_W{1'b0}}, cdb_val_i[k*WORD +: WORD]};
            end
`endif
        end
        return r;
    endfunction

    logic [ROB_W+WORD-1:0] w_r1, w_r2;
    logic [ROB_W-1:0]      src1_d, src2_d;
    logic [WORD-1:0]       val1_d, val2_d;
    logic [4:0]            dest_d;

    always_comb begin
        w_r1   = resolve(reg_src_i[0 +: ROB_W], rob_rdy_i[0], reg_val_i[0 +: WORD], rob_val_i[0 +: WORD]);
        w_r2   = resolve(reg_src_i[ROB_W +: ROB_W], rob_rdy_i[1], reg_val_i[WORD +: WORD], rob_val_i[WORD +: WORD]);
        src1_d = w_r1[WORD +: ROB_W];
        val1_d = w_r1[0 +: WORD];
        src2_d = w_r2[WORD +: ROB_W];
        val2_d = w_r2[0 +: WORD];
        dest_d = w_rd;
        case (w_ty)
            TYPE_R: ;
            TYPE_B, TYPE_S: dest_d = 5'd0;
            TYPE_I: begin
                src2_d = '0;
                val2_d = '0;
            end
            TYPE_U: begin
                src1_d = '0;
                src2_d = '0;
                val1_d = (w_opt == OPT_W'(OPT_LUI)) ? '0 : w_cur_pc;
                val2_d = '0;
            end
            TYPE_J: begin
                src1_d = '0;
                src2_d = '0;
                val1_d = w_cur_pc;
                val2_d = NEXT_PC_INC;
            end
            default: begin
                src1_d = '0;
                src2_d = '0;
                val1_d = '0;
                val2_d = '0;
                dest_d = 5'd0;
            end
        endcase
    end

    logic                 rs_ena_q, slb_ena_q, rob_ena_q, rn_ena_q, isld_q;
    logic [OPT_W-1:0]     opt_q;
    logic [2*ROB_W-1:0]   src_q;
    logic [2*WORD-1:0]    val_q;
    logic [WORD-1:0]      imm_q;
    logic [ROB_W-1:0]     rob_idx_q;
    logic [4:0]           dest_q;
    logic [64:0]          meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_ena_q  <= 1'b0;
            slb_ena_q <= 1'b0;
            rob_ena_q <= 1'b0;
            rn_ena_q  <= 1'b0;
            isld_q    <= 1'b0;
            opt_q     <= '0;
            src_q     <= '0;
            val_q     <= '0;
            imm_q     <= '0;
            rob_idx_q <= '0;
            dest_q    <= '0;
            meta_q    <= '0;
        end else begin
            rs_ena_q  <= w_pop & ~w_is_ls;
            slb_ena_q <= w_pop & w_is_ls;
            rob_ena_q <= w_pop;
            rn_ena_q  <= w_pop & (dest_d != 5'd0);
            if (w_pop) begin
                isld_q    <= w_is_ls & (w_ty == TYPE_I);
                opt_q     <= w_opt;
                src_q     <= {src2_d, src1_d};
                val_q     <= {val2_d, val1_d};
                imm_q     <= w_imm;
                rob_idx_q <= rob_idx_i;
                dest_q    <= dest_d;
                meta_q    <= w_head[PKT_META_LSB +: 65];
            end
        end
    end

    assign rs_ena_o      = rs_ena_q;
    assign slb_ena_o     = slb_ena_q;
    assign rob_ena_o     = rob_ena_q;
    assign rn_ena_o      = rn_ena_q;
    assign iss_isld_o    = isld_q;
    assign iss_opt_o     = opt_q;
    assign iss_src_o     = src_q;
    assign iss_val_o     = val_q;
    assign iss_imm_o     = imm_q;
    assign iss_rob_idx_o = rob_idx_q;
    assign rob_dest_o    = dest_q;
    assign rob_meta_o    = meta_q;

endmodule

`default_nettype wire

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised dispatcher with an in-order fetch buffer. It sits between the IFU and the RS/SLB/ROB. It buffers up to DEPTH fetched instructions and decodes the head through the external decoder. It resolves operands from the register file, the ROB and NUM_CDB broadcast channels, then issues one instruction per cycle on a shared registered bus, with per-target enables and the register rename request.

## Interface
- DEPTH, 4, buffer entries; power of 2, at least 2
- NUM_CDB, 2, CDB channels checked for forwarding
- ROB_W, 4, ROB index width; index 0 means "no dependency"
- OPT_W, 6, opcode-class width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global ready; low freezes all state, and enables go low
- flush  in  1  rollback; empties the buffer
- if_valid  in  1  fetch packet valid
- if_ready  out  1  buffer not full (combinational)
- if_pkt  in  97  {pb_tk, mis_pc[31:0], cur_pc[31:0], inst[31:0]}
- dec_inst  out  32  head instruction to the decoder
- dec_info  in  3+OPT_W+15+32+1  {is_ls, imm, rs2, rs1, rd, opt, ty}
- reg_rs  out  10  {rs2, rs1} of the head
- reg_src  in  2*ROB_W  rename tags {src2, src1}
- reg_val  in  64  architectural values {val2, val1}
- rob_full  in  1  ROB cannot accept
- rob_idx  in  ROB_W  ROB slot for the next issue
- rob_src  out  2*ROB_W  equal to reg_src (tag query)
- rob_rdy  in  2  queried tag has a committed-ready result
- rob_val  in  64  ROB values for the queried tags
- rs_full, slb_full  in  1 each  target full
- cdb_valid  in  NUM_CDB  channel broadcast valid
- cdb_src  in  NUM_CDB*ROB_W  channel tags; channel k at [k*ROB_W +: ROB_W]
- cdb_val  in  NUM_CDB*32  channel values
- rs_ena, slb_ena, rob_ena  out  1 each  issue pulses
- iss_opt  out  OPT_W  opcode
- iss_src  out  2*ROB_W  {src2, src1} pending tags
- iss_val  out  64  {val2, val1}
- iss_imm  out  32  immediate
- iss_rob_idx  out  ROB_W  ROB slot; also the rename tag
- iss_isld  out  1  SLB entry is a load
- rob_dest  out  5  destination register; 0 for B and S types
- rob_meta  out  65  {pb_tk, mis_pc, cur_pc}
- rn_ena  out  1  rename of rob_dest to iss_rob_idx

## Operation
- Buffer: circular, with rd_ptr and wr_ptr of width log2(DEPTH) that wrap naturally, and a count of width log2(DEPTH)+1.
  - if_ready = (count != DEPTH). If full, no push occurs, even when a pop happens the same cycle.
  - Push when rdy & !flush & if_valid & if_ready.
- Stall = rob_full | (is_ls ? slb_full : rs_full).
- Issue when rdy & !flush & count != 0 & !stall. Issue pops the head.
- Operand resolution, per side i:
  - src == 0: val = reg_val, tag 0.
  - else if rob_rdy[i]: val = rob_val, tag 0.
  - else if a CDB channel hits: val = cdb_val of the lowest-numbered matching channel, tag 0.
  - else: tag = src, val = 0.
- Type mapping:
  - R, B, S: both operands resolved.
  - I: src2 forced to 0 and val2 = 0.
  - U: val1 = (opt == OPT_LUI ? 0 : cur_pc); src1, src2 = 0.
  - J: val1 = cur_pc, val2 = 4; both tags 0.
- Target enables: is_ls sets slb_ena, with iss_isld = (ty == I); otherwise rs_ena. rob_ena is set on every issue.
- Rename: rn_ena = 1 when ty is not B/S and rd != 0. rd = 0 never renames.
- Unknown ty: issue proceeds with both tags 0 and rob_dest 0.

## Timing
- All issue outputs are registered. Enables are one-cycle pulses, cleared every cycle without an issue. Data outputs hold their last value.
- Reset: pointers, count, all enables, iss_*, rob_dest, rob_meta = 0. if_ready = 1 after reset.
- Latency: a packet pushed at edge t can issue at edge t+1, so enables are high during cycle t+1. Buffer-empty throughput is 1 per cycle.
- Flush on edge t: buffer empty after t, no issue at t, and the push at t is dropped.
- Flush has priority over issue and push. rst has priority over flush.
- Stall: head retained and outputs hold. Pushes continue until full.
- Simultaneous push and pop: count unchanged.

## Configuration
- DISPATCH_CDB_BYPASS_EN defined: the CDB forwarding step applies.
- Undefined: the CDB forwarding step is omitted and cdb_* inputs are ignored. A dependency whose result is not ROB-ready issues as a tag.

## Structure
- Shared package/utils: WORD width, TYPE_R/I/S/B/U/J, OPT_LUI, ZERO_ROB_IDX, NEXT_PC_INC (4), and the if_pkt and dec_info field offsets.
- Sub-module dispatch_fifo: parametrised DEPTH × 97-bit buffer providing push, pop, flush, full, empty and head.

## Test plan
- Reset, then R-type add x3,x1,x2, with reg_src = 0 and reg_val1/2 = 5/7 → next edge: rs_ena = 1, rob_ena = 1, iss_val = {7,5}, rn_ena = 1, rob_dest = 3.
- lw with src1 = 2 not ROB-ready and cdb_valid = 2'b11, cdb_src = {2,2}, values {0x20, 0x10} → slb_ena = 1, iss_isld = 1, val1 = 0x10 (channel 0 wins). With the macro off → src1 = 2.
- rs_full held high with 5 pushes at DEPTH = 4 → if_ready = 0 after 4. Release rs_full → 4 issues in consecutive cycles, in order, with pointers wrapping.
- flush while count = 3 and if_valid = 1 → no enables the next cycle, count = 0, if_ready = 1.
- auipc at pc 0x1000 → val1 = 0x1000. lui → val1 = 0. jal → val2 = 4. beq → rob_dest = 0, rn_ena = 0. addi x0 → rn_ena = 0.
